// File: rtl/btn_seq_pkg.sv
// Shared definitions for the button command sequencer: FSM state encodings
// and the width of the holdoff down-counter.
package btn_seq_pkg;

  // Sequencer states. All four encodings are used; the FSM still falls back
  // to StIdle from any value it does not recognise.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAck     = 2'd1,
    StIssue   = 2'd2,
    StHoldoff = 2'd3
  } seq_state_e;

  // Holdoff counter width; covers HOLDOFF_CYCLES up to 255.
  localparam int unsigned HoldCntW = 8;

endpackage

// File: rtl/btn_priority_picker.sv
// Combinational request picker. Scans the request vector starting at
// (ptr + 1) mod NUM_BUTTONS and returns the first requesting index. Passing
// ptr = NUM_BUTTONS-1 gives plain lowest-index-wins priority.
module btn_priority_picker
  import btn_seq_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned ID_W        = 2
) (
  input  logic [NUM_BUTTONS-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  output logic [ID_W-1:0]        winner,
  output logic                   any_req
);

  // One extra bit so ptr + 1 + k never wraps before the modulo fold.
  localparam int unsigned CandW = ID_W + 1;
  localparam logic [CandW-1:0] NumB = CandW'(NUM_BUTTONS);

  logic [CandW-1:0] cand;

  // Walk the candidates in search order; the first requester wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 0; k < int'(NUM_BUTTONS); k++) begin
      cand = {1'b0, ptr} + CandW'(k + 1);
      if (cand >= NumB) begin
        cand = cand - NumB;
      end
      // Shift-and-mask avoids indexing req with a wider select.
      if (!any_req && (|(req & (NUM_BUTTONS'(1) << cand)))) begin
        winner  = cand[ID_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_command_sequencer.sv
// Button command sequencer: arbitrates detector wasPressed flags, acks one
// detector per grant, issues a valid/ready command carrying the winning index,
// then enforces a holdoff gap before the next grant.
// Build option: define BTN_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it, fixed priority (lowest index wins) and no pointer register.
module button_command_sequencer
  import btn_seq_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS    = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned HOLDOFF_CYCLES = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] wasPressed,
  output logic [NUM_BUTTONS-1:0] ackPress,
  output logic                   cmdValid,
  output logic [ID_W-1:0]        cmdId,
  input  logic                   cmdReady,
  output logic                   busy
);

  localparam logic [HoldCntW-1:0] HoldLoad = HoldCntW'(HOLDOFF_CYCLES);
  localparam logic [ID_W-1:0]     LastIdx  = ID_W'(NUM_BUTTONS - 1);

  seq_state_e          state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [HoldCntW-1:0] hold_q,  hold_d;

  logic [ID_W-1:0]     search_ptr;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;

`ifdef BTN_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_q;

  // Round-robin pointer: remembers the last grant, updated on entry to StAck.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q <= LastIdx;
    end else if ((state_q == StIdle) && pick_any) begin
      rr_q <= pick_id;
    end
  end

  assign search_ptr = rr_q;
`else
  // Fixed priority: searching from LastIdx + 1 means index 0 always goes first.
  assign search_ptr = LastIdx;
`endif

  btn_priority_picker #(
    .NUM_BUTTONS (NUM_BUTTONS),
    .ID_W        (ID_W)
  ) u_picker (
    .req     (wasPressed),
    .ptr     (search_ptr),
    .winner  (pick_id),
    .any_req (pick_any)
  );

  // State, grant and holdoff counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: grant in StIdle, one ack cycle, wait for the handshake,
  // then count the holdoff gap down to 1 before returning to StIdle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_id;
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = StIssue;
      end
      StIssue: begin
        // cmdValid is high for the whole of StIssue, so cmdReady alone is the handshake.
        if (cmdReady) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StHoldoff;
            hold_d  = HoldLoad;
          end
        end
      end
      StHoldoff: begin
        // Exiting on <= 1 also recovers from a zero count that should never occur.
        if (hold_q <= HoldCntW'(1)) begin
          state_d = StIdle;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HoldCntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs decoded from registered state and grant only.
  always_comb begin
    ackPress = '0;
    cmdValid = 1'b0;
    cmdId    = '0;
    busy     = 1'b1;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StAck: begin
        ackPress = NUM_BUTTONS'(1) << grant_q;
      end
      StIssue: begin
        cmdValid = 1'b1;
        cmdId    = grant_q;
      end
      StHoldoff: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_command_sequencer.sv
// Self-checking bench for button_command_sequencer. A transaction-level model
// (grant age / accepted flag / remaining holdoff) predicts every output each
// cycle; directed tests add literal expectations. A second instance with no
// holdoff runs continuously with all buttons requesting.
module tb_button_command_sequencer;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int HOLD = 8;
`ifdef BTN_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   press_set = '0;
  logic [N-1:0]   hold_mask = '0;
  logic [N-1:0]   pend = '0;
  logic [N-1:0]   wasPressed;
  logic           cmdReady = 1'b0;
  logic [N-1:0]   ackPress;
  logic           cmdValid;
  logic [IDW-1:0] cmdId;
  logic           busy;

  logic [N-1:0]   ack0;
  logic           valid0;
  logic [IDW-1:0] id0;
  logic           busy0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clock = ~clock;

  // Detector bank: flags set by press pulses, cleared by the sequencer's ack.
  always @(posedge clock or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= (pend & ~ackPress) | press_set;
  end
  assign wasPressed = pend | hold_mask;

  button_command_sequencer #(
    .NUM_BUTTONS    (N),
    .ID_W           (IDW),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wasPressed (wasPressed),
    .ackPress   (ackPress),
    .cmdValid   (cmdValid),
    .cmdId      (cmdId),
    .cmdReady   (cmdReady),
    .busy       (busy)
  );

  button_command_sequencer #(
    .NUM_BUTTONS    (N),
    .ID_W           (IDW),
    .HOLDOFF_CYCLES (0)
  ) dut_nohold (
    .clock      (clock),
    .reset      (reset),
    .wasPressed (4'b1111),
    .ackPress   (ack0),
    .cmdValid   (valid0),
    .cmdId      (id0),
    .cmdReady   (1'b1),
    .busy       (busy0)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy  = 1'b0;
  bit m_taken = 1'b0;
  int m_age   = 0;
  int m_hold  = 0;
  int m_id    = 0;
  int m_last  = N - 1;

  function automatic int pick(input logic [N-1:0] req, input int last);
    int start;
    start = RR ? (last + 1) % N : 0;
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  // Model advance: grant when free, one ack cycle, wait for ready, then HOLD busy cycles.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_taken <= 1'b0;
      m_age   <= 0;
      m_hold  <= 0;
      m_id    <= 0;
      m_last  <= N - 1;
    end else if (!m_busy) begin
      if (wasPressed != '0) begin
        m_id    <= pick(wasPressed, m_last);
        m_last  <= pick(wasPressed, m_last);
        m_busy  <= 1'b1;
        m_age   <= 0;
        m_taken <= 1'b0;
      end
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (!m_taken) begin
      if (cmdReady) begin
        m_taken <= 1'b1;
        m_hold  <= HOLD;
        if (HOLD == 0) m_busy <= 1'b0;
      end
    end else begin
      m_hold <= m_hold - 1;
      if (m_hold <= 1) m_busy <= 1'b0;
    end
  end

  logic [N-1:0]   e_ack;
  logic           e_valid;
  logic [IDW-1:0] e_id;
  logic           e_busy;

  // Expected outputs from the model's transaction view.
  always_comb begin
    e_ack   = (m_busy && m_age == 0) ? (N'(1) << m_id) : '0;
    e_valid = m_busy && (m_age != 0) && !m_taken;
    e_id    = e_valid ? IDW'(m_id) : '0;
    e_busy  = m_busy;
  end

  // Compare every cycle, mid-cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_ackPress", 32'(ackPress), 32'(e_ack));
      check("model_cmdValid", 32'(cmdValid), 32'(e_valid));
      check("model_cmdId",    32'(cmdId),    32'(e_id));
      check("model_busy",     32'(busy),     32'(e_busy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    #1;
    press_set = '0;
    hold_mask = '0;
    cmdReady  = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cmdValid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_valid at %0t: cmdValid stayed 0, required 1", $time);
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ackPress != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_ack at %0t: ackPress stayed 0, required nonzero", $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    bit ok;
    int exp2 [4];
    int exp6 [5];
    int ids  [5];
    int at   [5];
    int got_n;
    int cyc;

    if (RR) begin
      exp2 = '{1, 3, 1, 3};
      exp6 = '{0, 1, 2, 3, 0};
    end else begin
      exp2 = '{1, 1, 1, 1};
      exp6 = '{0, 0, 0, 0, 0};
    end

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ackPress", 32'(ackPress), 32'h0);
    check("rst_cmdValid", 32'(cmdValid), 32'h0);
    check("rst_cmdId",    32'(cmdId),    32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1: single press on button 2 with ready held high
    cmdReady  = 1'b1;
    press_set = 4'b0100;
    @(negedge clock);
    press_set = '0;
    wait_ack(ok);
    if (ok) begin
      check("t1_ack", 32'(ackPress), 32'h4);
      @(negedge clock);
      check("t1_ack_once", 32'(ackPress), 32'h0);
      check("t1_valid",    32'(cmdValid), 32'h1);
      check("t1_id",       32'(cmdId),    32'h2);
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        check("t1_hold_busy",  32'(busy),     32'h1);
        check("t1_hold_valid", 32'(cmdValid), 32'h0);
      end
      @(negedge clock);
      check("t1_back_idle", 32'(busy), 32'h0);
    end

    // 2: 1010 held, sequence of grants
    do_reset();
    cmdReady  = 1'b1;
    hold_mask = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      wait_valid(ok);
      if (!ok) break;
      check("t2_grant", 32'(cmdId), 32'(exp2[g]));
    end

    // 3: stall in ISSUE for 20 cycles, then accept
    do_reset();
    cmdReady  = 1'b0;
    press_set = 4'b0001;
    @(negedge clock);
    press_set = '0;
    wait_valid(ok);
    if (ok) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        check("t3_stall_valid", 32'(cmdValid), 32'h1);
        check("t3_stall_id",    32'(cmdId),    32'h0);
        check("t3_stall_ack",   32'(ackPress), 32'h0);
      end
      cmdReady = 1'b1;
      @(negedge clock);
      check("t3_accept_valid", 32'(cmdValid), 32'h0);
      check("t3_accept_busy",  32'(busy),     32'h1);
    end

    // 4: press during HOLDOFF waits for IDLE
    do_reset();
    cmdReady  = 1'b1;
    press_set = 4'b0010;
    @(negedge clock);
    press_set = '0;
    wait_ack(ok);
    if (ok) begin
      @(negedge clock);
      check("t4_id", 32'(cmdId), 32'h1);
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        check("t4_hold_ack",  32'(ackPress), 32'h0);
        check("t4_hold_busy", 32'(busy),     32'h1);
        if (i == 1) press_set = 4'b1000;
        if (i == 2) press_set = '0;
      end
      @(negedge clock);
      check("t4_idle_busy", 32'(busy),     32'h0);
      check("t4_idle_ack",  32'(ackPress), 32'h0);
      @(negedge clock);
      check("t4_late_ack", 32'(ackPress), 32'h8);
    end

    // 5: reset pulse while in ISSUE
    do_reset();
    cmdReady  = 1'b0;
    hold_mask = 4'b1111;
    wait_valid(ok);
    if (ok) begin
      check("t5_first_id", 32'(cmdId), 32'h0);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("t5_rst_ack",   32'(ackPress), 32'h0);
      check("t5_rst_valid", 32'(cmdValid), 32'h0);
      check("t5_rst_id",    32'(cmdId),    32'h0);
      check("t5_rst_busy",  32'(busy),     32'h0);
      @(negedge clock);
      #1;
      reset    = 1'b0;
      cmdReady = 1'b1;
      wait_ack(ok);
      if (ok) begin
        check("t5_regrant_ack", 32'(ackPress), 32'h1);
        @(negedge clock);
        check("t5_regrant_id", 32'(cmdId), 32'h0);
      end
    end

    // 6: zero-holdoff instance, all buttons requesting
    do_reset();
    got_n = 0;
    cyc   = 0;
    for (int i = 0; i < 60 && got_n < 5; i++) begin
      @(negedge clock);
      cyc++;
      if (valid0) begin
        ids[got_n] = int'(id0);
        at[got_n]  = cyc;
        got_n++;
      end
    end
    check("t6_count", 32'(got_n), 32'd5);
    if (got_n > 0) check("t6_first_cycle", 32'(at[0]), 32'd2);
    for (int k = 0; k < got_n; k++) begin
      check("t6_id", 32'(ids[k]), 32'(exp6[k]));
      if (k > 0) check("t6_gap", 32'(at[k] - at[k-1]), 32'd3);
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
